fetch_controller: RTL and testbench

Sequences the combinational instruction memory: owns the 64-bit program counter, presents it to the memory, and registers the returned word into a one-entry valid/ready slot toward decode. Handles branch/jump redirects, stalls and halt. Converts the memory's invalid-address flag into a sticky fault for the trap logic. Sits between the instruction memory and the decode stage of the sequential core.

---
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_controller.sv | 99 +++++++++
 tb/tb_fetch_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch controller bus: instruction-memory side, decode-side valid/ready slot, and control/status.
// The master modport is the fetch controller; the slave modport is the surrounding core or bench.
interface fetch_if;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] mem_pc;
    logic [31:0] mem_instr;
    logic        mem_inv_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  start, stall, redirect_valid, redirect_pc, mem_instr, mem_inv_addr, out_ready,
        output mem_pc, out_valid, out_instr, out_pc, fault, fault_pc, halted, fetch_count
    );

    modport slave (
        output start, stall, redirect_valid, redirect_pc, mem_instr, mem_inv_addr, out_ready,
        input  mem_pc, out_valid, out_instr, out_pc, fault, fault_pc, halted, fetch_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Owns the PC, fetches from combinational instruction memory into a one-entry valid/ready slot.
// Latency 1 cycle PC->slot; redirect flushes the slot; optional FETCH_COUNT_EN builds the delivered counter.
module fetch_controller #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, FAULT, DONE} state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [63:0] out_pc_q;
    logic        fault_q;
    logic [63:0] fault_pc_q;
    logic        halted_q;

    logic        slot_free;
    logic        fetch_go;
    logic        accept;
    logic [63:0] pc_d;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign fetch_go  = (state_q == RUN) && slot_free && !bus.stall && !bus.redirect_valid;
    // A flush in the same cycle as out_ready means decode did not take the slot.
    assign accept    = out_valid_q && bus.out_ready && !bus.redirect_valid;
    assign pc_d      = pc_q + 64'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 64'h0;
            fault_q     <= 1'b0;
            fault_pc_q  <= 64'h0;
            halted_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.redirect_valid) pc_q <= bus.redirect_pc;
            if (bus.start) state_q <= RUN;
        end else if (bus.redirect_valid) begin
            pc_q        <= bus.redirect_pc;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            halted_q    <= 1'b0;
            state_q     <= RUN;
        end else begin
            if (fetch_go) begin
                if (bus.mem_inv_addr) begin
                    state_q     <= FAULT;
                    fault_q     <= 1'b1;
                    fault_pc_q  <= pc_q;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= bus.mem_instr;
                    out_pc_q    <= pc_q;
                    pc_q        <= pc_d;
                    if (bus.mem_instr == HALT_INSTR) state_q <= DONE;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // In DONE the only slot left is the halt instruction itself.
            if (state_q == DONE && accept) halted_q <= 1'b1;
        end
    end

    assign bus.mem_pc    = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.fault     = fault_q;
    assign bus.fault_pc  = fault_pc_q;
    assign bus.halted    = halted_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'h0;
        end else if (accept && fetch_count_q != 32'hFFFF_FFFF) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`else
    assign bus.fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed table plus randomized run of fetch_controller against a behavioural model.
module tb_fetch_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_controller #(.RESET_PC(64'h0), .HALT_INSTR(32'h00000073)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        if (pc == 64'h0)  return 32'h00500093;
        if (pc == 64'h4)  return 32'h00100113;
        if (pc == 64'hC || pc == 64'h2C) return 32'h00000073;
        return {pc[31:2], 2'b11} | 32'h00000100;
    endfunction

    function automatic logic mem_inv(input logic [63:0] pc);
        return (pc[1:0] != 2'b00) || (pc[63:12] == 52'h1);
    endfunction

    assign bus.mem_instr    = mem_word(bus.mem_pc);
    assign bus.mem_inv_addr = mem_inv(bus.mem_pc);

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_COUNT_EN
        return c;
`else
        return 32'h0 & c;
`endif
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check_state(input string name, input bit vld, input logic [63:0] opc,
                               input logic [31:0] ins, input logic [63:0] mpc, input bit flt,
                               input logic [63:0] fpc, input bit hlt, input logic [31:0] cnt);
        bit ok;
        ok = (bus.out_valid === vld) && (bus.mem_pc === mpc) && (bus.fault === flt) &&
             (bus.halted === hlt) && (bus.fetch_count === cnt);
        if (vld) ok = ok && (bus.out_pc === opc) && (bus.out_instr === ins);
        if (flt) ok = ok && (bus.fault_pc === fpc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got vld=%0b opc=%h ins=%h mpc=%h flt=%0b fpc=%h hlt=%0b cnt=%0d; want vld=%0b opc=%h ins=%h mpc=%h flt=%0b fpc=%h hlt=%0b cnt=%0d",
                     name, bus.out_valid, bus.out_pc, bus.out_instr, bus.mem_pc, bus.fault,
                     bus.fault_pc, bus.halted, bus.fetch_count, vld, opc, ins, mpc, flt, fpc, hlt, cnt);
        end
    endtask

    task automatic check_reset_regs(input string name);
        checks++;
        if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0 || bus.fault_pc !== 64'h0) begin
            errors++;
            $display("FAIL %s: got out_pc=%h out_instr=%h fault_pc=%h; want all zero",
                     name, bus.out_pc, bus.out_instr, bus.fault_pc);
        end
    endtask

    task automatic set_in(input bit st, input bit sl, input bit rd, input logic [63:0] rpc, input bit rdy);
        bus.start          = st;
        bus.stall          = sl;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
    endtask

    typedef struct {
        bit          st, sl, rd;
        logic [63:0] rpc;
        bit          rdy;
        bit          e_vld;
        logic [63:0] e_opc;
        logic [31:0] e_ins;
        logic [63:0] e_mpc;
        bit          e_flt;
        bit          e_hlt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit st, input bit sl, input bit rd, input logic [63:0] rpc, input bit rdy,
                       input bit vld, input logic [63:0] opc, input logic [31:0] ins,
                       input logic [63:0] mpc, input bit flt, input bit hlt, input logic [31:0] cnt);
        vec_t v;
        v.st = st; v.sl = sl; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_vld = vld; v.e_opc = opc; v.e_ins = ins; v.e_mpc = mpc;
        v.e_flt = flt; v.e_hlt = hlt; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Behavioural model: mode 0 idle, 1 running, 2 faulted, 3 halting/done.
    int          m_mode;
    logic [63:0] m_pc;
    bit          m_vld;
    logic [63:0] m_opc;
    logic [31:0] m_ins;
    bit          m_flt;
    logic [63:0] m_fpc;
    bit          m_hlt;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 64'h0; m_vld = 0; m_opc = 64'h0; m_ins = 32'h0;
        m_flt = 0; m_fpc = 64'h0; m_hlt = 0; m_cnt = 32'h0;
    endtask

    task automatic model_step(input bit st, input bit sl, input bit rd, input logic [63:0] rpc, input bit rdy);
        bit taken;
        taken = m_vld && rdy && !rd;
        if (taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_mode == 0) begin
            if (rd) m_pc = rpc;
            if (st) m_mode = 1;
        end else if (rd) begin
            m_pc = rpc; m_vld = 0; m_flt = 0; m_hlt = 0; m_mode = 1;
        end else begin
            if (m_mode == 3 && taken) m_hlt = 1;
            if (m_mode == 1 && (!m_vld || rdy) && !sl) begin
                if (mem_inv(m_pc)) begin
                    m_mode = 2; m_flt = 1; m_fpc = m_pc; m_vld = 0;
                end else begin
                    m_vld = 1; m_opc = m_pc; m_ins = mem_word(m_pc);
                    if (m_ins == 32'h00000073) m_mode = 3;
                    m_pc = m_pc + 64'd4;
                end
            end else if (rdy) begin
                m_vld = 0;
            end
        end
    endtask

    logic [63:0] targets [7] = '{64'h0, 64'h40, 64'h1000, 64'h20, 64'h42,
                                 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFC};

    initial begin
        set_in(0, 0, 0, 64'h0, 0);
        #12;
        check_state("reset", 0, 64'h0, 32'h0, 64'h0, 0, 64'h0, 0, 32'h0);
        check_reset_regs("reset_regs");
        @(negedge clk);
        rst_n = 1'b1;

        //   st sl rd rpc        rdy  vld opc      ins           mpc      flt hlt cnt
        add(1, 0, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h0,    0, 0, 0);
        add(0, 0, 0, 64'h0,    1,   1, 64'h0,  32'h00500093, 64'h4,    0, 0, 0);
        add(0, 0, 0, 64'h0,    0,   1, 64'h0,  32'h00500093, 64'h4,    0, 0, 0);
        add(0, 0, 0, 64'h0,    0,   1, 64'h0,  32'h00500093, 64'h4,    0, 0, 0);
        add(0, 0, 0, 64'h0,    0,   1, 64'h0,  32'h00500093, 64'h4,    0, 0, 0);
        add(0, 0, 0, 64'h0,    1,   1, 64'h4,  32'h00100113, 64'h8,    0, 0, 1);
        add(0, 0, 0, 64'h0,    1,   1, 64'h8,  32'h0000010B, 64'hC,    0, 0, 2);
        add(0, 0, 1, 64'h40,   1,   0, 64'h0,  32'h0,        64'h40,   0, 0, 2);
        add(0, 0, 0, 64'h0,    1,   1, 64'h40, 32'h00000143, 64'h44,   0, 0, 2);
        add(0, 1, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h44,   0, 0, 3);
        add(0, 1, 0, 64'h0,    0,   0, 64'h0,  32'h0,        64'h44,   0, 0, 3);
        add(0, 0, 1, 64'h1000, 1,   0, 64'h0,  32'h0,        64'h1000, 0, 0, 3);
        add(0, 0, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h1000, 1, 0, 3);
        add(0, 0, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h1000, 1, 0, 3);
        add(1, 0, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h1000, 1, 0, 3);
        add(0, 0, 1, 64'h0,    1,   0, 64'h0,  32'h0,        64'h0,    0, 0, 3);
        add(0, 0, 0, 64'h0,    1,   1, 64'h0,  32'h00500093, 64'h4,    0, 0, 3);
        add(0, 0, 0, 64'h0,    1,   1, 64'h4,  32'h00100113, 64'h8,    0, 0, 4);
        add(0, 0, 0, 64'h0,    1,   1, 64'h8,  32'h0000010B, 64'hC,    0, 0, 5);
        add(0, 0, 0, 64'h0,    0,   1, 64'h8,  32'h0000010B, 64'hC,    0, 0, 5);
        add(0, 0, 0, 64'h0,    1,   1, 64'hC,  32'h00000073, 64'h10,   0, 0, 6);
        add(0, 0, 0, 64'h0,    0,   1, 64'hC,  32'h00000073, 64'h10,   0, 0, 6);
        add(0, 0, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h10,   0, 1, 7);
        add(0, 0, 0, 64'h0,    1,   0, 64'h0,  32'h0,        64'h10,   0, 1, 7);
        add(0, 0, 1, 64'h40,   1,   0, 64'h0,  32'h0,        64'h40,   0, 0, 7);
        add(0, 0, 0, 64'h0,    1,   1, 64'h40, 32'h00000143, 64'h44,   0, 0, 7);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            set_in(vecs[i].st, vecs[i].sl, vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_state($sformatf("dir%0d", i), vecs[i].e_vld, vecs[i].e_opc, vecs[i].e_ins,
                        vecs[i].e_mpc, vecs[i].e_flt, 64'h1000, vecs[i].e_hlt, cnt_exp(vecs[i].e_cnt));
        end

        // Asynchronous reset in the middle of a cycle with a valid slot.
        @(negedge clk);
        set_in(0, 0, 0, 64'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_state("async_reset", 0, 64'h0, 32'h0, 64'h0, 0, 64'h0, 0, 32'h0);
        check_reset_regs("async_reset_regs");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            bit st, sl, rd, rdy;
            logic [63:0] rpc;
            @(negedge clk);
            st  = ($urandom_range(0, 1) == 1);
            sl  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = targets[$urandom_range(0, 6)];
            rdy = ($urandom_range(0, 9) < 7);
            set_in(st, sl, rd, rpc, rdy);
            model_step(st, sl, rd, rpc, rdy);
            @(posedge clk);
            #1;
            check_state($sformatf("rnd%0d", i), m_vld, m_opc, m_ins, m_pc, m_flt, m_fpc, m_hlt, cnt_exp(m_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
